// File: rtl/store_commit_buffer.sv
// store_commit_buffer: circular store queue with speculative/committed split, in-order
// drain to the dcache and youngest-match store-to-load forwarding.
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [31:0] enq_addr,
  input  logic [31:0] enq_data,
  input  logic [3:0]  enq_be,
  input  logic        fire_store,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] fwd_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_be,
  output logic        empty,
  output logic        commit_err
);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  logic [PTR_W:0]   head_q, head_d, cptr_q, cptr_d, tail_q, tail_d, cnt;
  logic [PTR_W-1:0] idx;
  logic             err_q, full, enq_fire;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  assign full          = (tail_q[PTR_W-1:0] == head_q[PTR_W-1:0]) && (tail_q[PTR_W] != head_q[PTR_W]);
  assign enq_ready     = !full && !flush;
  assign enq_fire      = enq_valid && enq_ready;
  assign mem_req_valid = head_q != cptr_q;
  assign mem_addr      = {addr_q[head_q[PTR_W-1:0]][31:2], 2'b00};
  assign mem_wdata     = data_q[head_q[PTR_W-1:0]];
  assign mem_be        = be_q[head_q[PTR_W-1:0]];
  assign empty         = head_q == tail_q;
  assign commit_err    = err_q;
  assign cnt           = tail_q - head_q;
  always_comb begin
    head_d = (mem_req_valid && mem_req_ready) ? head_q + PTR_ONE : head_q;
    cptr_d = (fire_store && cptr_q != tail_q) ? cptr_q + PTR_ONE : cptr_q;
    tail_d = flush ? cptr_d : enq_fire ? tail_q + PTR_ONE : tail_q;
  end
  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_be   = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q[PTR_W-1:0] + PTR_W'(i);
      if ((PTR_W+1)'(i) < cnt && addr_q[idx][31:2] == fwd_addr[31:2]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
        fwd_be   = be_q[idx];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
      if (fire_store && cptr_q == tail_q) err_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_q[tail_q[PTR_W-1:0]] <= enq_addr;
      data_q[tail_q[PTR_W-1:0]] <= enq_data;
      be_q[tail_q[PTR_W-1:0]]   <= enq_be;
    end
  end
endmodule
